// File: rtl/cvbs_pkg.sv
// Shared constants and types for the composite video (CVBS) generator and
// the matching sync detector: PAL timing at a 24 MHz sample clock, level
// codes, line-type enum and a saturating level helper.
package cvbs_pkg;

    localparam int LINE      = 1536;
    localparam int FPORCH    = 40;
    localparam int HS        = 113;
    localparam int BPORCH    = 137;
    localparam int SSYNC     = 48;
    localparam int LSYNC     = 720;
    localparam int LINES     = 312;
    localparam int TOP_BLANK = 23;

    localparam logic [5:0] BLACK    = 6'd12;
    localparam logic [5:0] SYNC_LVL = 6'd0;

    typedef enum logic [2:0] {
        BROAD,
        BROAD_SHORT,
        SHORT,
        BLANK,
        VIDEO
    } line_type_e;

    // Adds a luma offset on top of a base level, clamping at full scale
    // instead of wrapping around to the sync region.
    function automatic logic [5:0] satAdd(input logic [5:0] base, input logic [5:0] luma);
        logic [6:0] sum;
        sum = {1'b0, base} + {1'b0, luma};
        return sum[6] ? 6'h3F : sum[5:0];
    endfunction

endpackage

// File: rtl/cvbs_timing_counter.sv
// Pixel/line position counters for the CVBS generator plus the registered
// line-type state that tells the level decoder which pulse pattern applies
// to the current line. Everything advances only on clock-enable cycles.
module cvbs_timing_counter
    import cvbs_pkg::*;
#(
    parameter int P_LINE      = LINE,
    parameter int P_LINES     = LINES,
    parameter int P_TOP_BLANK = TOP_BLANK
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    output logic [10:0] o_pixel,
    output logic [8:0]  o_line,
    output line_type_e  o_type,
    output logic        o_vsync
);

    localparam logic [10:0] C_PIX_LAST  = 11'(P_LINE - 1);
    localparam logic [8:0]  C_LINE_LAST = 9'(P_LINES - 1);
    localparam logic [8:0]  C_TOP_BLANK = 9'(P_TOP_BLANK);

    logic [10:0] r_pixel;
    logic [8:0]  r_line;
    line_type_e  r_type;
    line_type_e  w_nextType;
    logic        w_eol;

    assign w_eol   = (r_pixel == C_PIX_LAST);
    assign o_pixel = r_pixel;
    assign o_line  = r_line;

    // Position counters: pixel runs across the line, line steps at pixel wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel <= '0;
            r_line  <= '0;
        end else if (ce) begin
            if (w_eol) begin
                r_pixel <= '0;
                r_line  <= (r_line == C_LINE_LAST) ? 9'd0 : r_line + 9'd1;
            end else begin
                r_pixel <= r_pixel + 11'd1;
            end
        end
    end

    // Line-type state register, stepped only when a line finishes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_type <= BROAD;
        end else if (ce && w_eol) begin
            r_type <= w_nextType;
        end
    end

    // Next line type, chosen from the line that is just ending.
    always_comb begin
        w_nextType = r_type;
        case (r_type)
            BROAD:       if (r_line == 9'd1)        w_nextType = BROAD_SHORT;
            BROAD_SHORT:                             w_nextType = SHORT;
            SHORT:       if (r_line == 9'd5)        w_nextType = BLANK;
            BLANK:       if (r_line == C_TOP_BLANK) w_nextType = VIDEO;
            VIDEO:       if (r_line == C_LINE_LAST) w_nextType = BROAD;
            default:                                 w_nextType = BROAD;
        endcase
    end

    // Exported view of the state: the type itself and the vertical-interval flag.
    always_comb begin
        o_type  = r_type;
        o_vsync = (r_type == BROAD) || (r_type == BROAD_SHORT) || (r_type == SHORT);
    end

endmodule

// File: rtl/cvbs_syncgen.sv
// CVBS transmitter: turns the current (pixel, line, line type) into a 6-bit
// composite sample with sync tips, porches, vertical broad/short pulses and
// saturated active video. All outputs are registered one enable-cycle after
// the position they describe.
module cvbs_syncgen
    import cvbs_pkg::*;
#(
    parameter int         P_LINE      = LINE,
    parameter int         P_FPORCH    = FPORCH,
    parameter int         P_HS        = HS,
    parameter int         P_BPORCH    = BPORCH,
    parameter int         P_SSYNC     = SSYNC,
    parameter int         P_LSYNC     = LSYNC,
    parameter int         P_LINES     = LINES,
    parameter int         P_TOP_BLANK = TOP_BLANK,
    parameter logic [5:0] P_BLACK     = BLACK,
    parameter logic [5:0] P_SYNC_LVL  = SYNC_LVL
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [5:0]  pixel_in,
    output logic [5:0]  cvbs,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [8:0]  line,
    output logic [10:0] pixel
);

    if ((P_FPORCH + P_HS + P_BPORCH >= P_LINE) || (P_LINE / 2 + P_LSYNC > P_LINE)) begin : g_badParams
        $error("cvbs_syncgen: timing parameters do not fit inside one line");
    end

    localparam logic [10:0] C_HALF      = 11'(P_LINE / 2);
    localparam logic [10:0] C_LSYNC     = 11'(P_LSYNC);
    localparam logic [10:0] C_SSYNC     = 11'(P_SSYNC);
    localparam logic [10:0] C_H_LSYNC   = 11'(P_LINE / 2 + P_LSYNC);
    localparam logic [10:0] C_H_SSYNC   = 11'(P_LINE / 2 + P_SSYNC);
    localparam logic [10:0] C_HS_START  = 11'(P_FPORCH);
    localparam logic [10:0] C_HS_END    = 11'(P_FPORCH + P_HS);
    localparam logic [10:0] C_ACT_START = 11'(P_FPORCH + P_HS + P_BPORCH);

    logic [10:0] w_pixel;
    logic [8:0]  w_line;
    line_type_e  w_type;
    logic        w_vsync;
    logic        w_sync;
    logic        w_act;
    logic        w_hWindow;
    logic [5:0]  w_level;

    logic [5:0]  r_cvbs;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_active;

    cvbs_timing_counter #(
        .P_LINE      (P_LINE),
        .P_LINES     (P_LINES),
        .P_TOP_BLANK (P_TOP_BLANK)
    ) u_timing (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .o_pixel (w_pixel),
        .o_line  (w_line),
        .o_type  (w_type),
        .o_vsync (w_vsync)
    );

    assign w_hWindow = (w_pixel >= C_HS_START) && (w_pixel < C_HS_END);
    assign w_level   = satAdd(P_BLACK, pixel_in);

    // Decide whether this position is a sync tip or an active-video sample.
    always_comb begin
        w_sync = 1'b0;
        w_act  = 1'b0;
        case (w_type)
            BROAD:       w_sync = (w_pixel < C_LSYNC) ||
                                  ((w_pixel >= C_HALF) && (w_pixel < C_H_LSYNC));
            BROAD_SHORT: w_sync = (w_pixel < C_LSYNC) ||
                                  ((w_pixel >= C_HALF) && (w_pixel < C_H_SSYNC));
            SHORT:       w_sync = (w_pixel < C_SSYNC) ||
                                  ((w_pixel >= C_HALF) && (w_pixel < C_H_SSYNC));
            BLANK:       w_sync = w_hWindow;
            VIDEO: begin
                w_sync = w_hWindow;
                w_act  = (w_pixel >= C_ACT_START);
            end
            default:     w_sync = 1'b0;
        endcase
    end

    // Output stage: register the decoded sample and flags on each enabled cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cvbs   <= P_BLACK;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_active <= 1'b0;
        end else if (ce) begin
            r_cvbs   <= w_sync ? P_SYNC_LVL : (w_act ? w_level : P_BLACK);
            r_hsync  <= w_sync;
            r_vsync  <= w_vsync;
            r_active <= w_act;
        end
    end

    assign cvbs   = r_cvbs;
    assign hsync  = r_hsync;
    assign vsync  = r_vsync;
    assign active = r_active;
    assign line   = w_line;
    assign pixel  = w_pixel;

endmodule

// File: tb/tb_cvbs_syncgen.sv
// Self-checking bench for cvbs_syncgen: a table of hand-computed samples at
// pulse edges and frame wrap, then randomized clock-enable and luma traffic
// checked against a position-based reference model, with mid-line resets.
// The frame is shortened to 26 lines so a full frame wrap fits the run.
module tb_cvbs_syncgen;

    localparam int T_LINE      = 1536;
    localparam int T_LINES     = 26;
    localparam int T_TOP_BLANK = 23;
    localparam int T_FRAME     = T_LINE * T_LINES;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic [5:0]  pixel_in;
    logic [5:0]  cvbs;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic [8:0]  line;
    logic [10:0] pixel;

    int tests;
    int fails;

    typedef struct {
        int l;
        int p;
        int pin;
        int cv;
        int hs;
        int vs;
        int act;
    } vec_t;

    vec_t vecs[28];

    int mN;
    int mCv;
    int mHs;
    int mVs;
    int mAct;
    int tabN;

    cvbs_syncgen #(
        .P_LINES     (T_LINES),
        .P_TOP_BLANK (T_TOP_BLANK)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .pixel_in (pixel_in),
        .cvbs     (cvbs),
        .hsync    (hsync),
        .vsync    (vsync),
        .active   (active),
        .line     (line),
        .pixel    (pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: sample implied by the spec's line rules for position (l, p).
    task automatic refSample(input int l, input int p, input int pin,
                             output int cv, output int hs, output int vs, output int act);
        int h;
        bit sync;
        h = T_LINE / 2;
        act = 0;
        if (l <= 1)
            sync = (p < 720) || (p >= h && p < h + 720);
        else if (l == 2)
            sync = (p < 720) || (p >= h && p < h + 48);
        else if (l <= 5)
            sync = (p < 48) || (p >= h && p < h + 48);
        else begin
            sync = (p >= 40) && (p < 40 + 113);
            act  = (l > T_TOP_BLANK && p >= 40 + 113 + 137) ? 1 : 0;
        end
        hs = sync ? 1 : 0;
        vs = (l < 6) ? 1 : 0;
        if (sync)
            cv = 0;
        else if (act == 1)
            cv = (12 + pin > 63) ? 63 : 12 + pin;
        else
            cv = 12;
    endtask

    task automatic modelReset();
        mN   = 0;
        mCv  = 12;
        mHs  = 0;
        mVs  = 0;
        mAct = 0;
    endtask

    // Plain clocking used by the table phase (no model update).
    task automatic clockOnce(input logic ceVal, input logic [5:0] pin);
        ce       = ceVal;
        pixel_in = pin;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ceVal, input logic [5:0] pin);
        int cv, hs, vs, act;
        clockOnce(ceVal, pin);
        if (ceVal) begin
            refSample(mN / T_LINE, mN % T_LINE, int'(pin), cv, hs, vs, act);
            mCv  = cv;
            mHs  = hs;
            mVs  = vs;
            mAct = act;
            mN   = (mN + 1) % T_FRAME;
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " cvbs"},   int'(cvbs),   mCv);
        checkValue({tag, " hsync"},  int'(hsync),  mHs);
        checkValue({tag, " vsync"},  int'(vsync),  mVs);
        checkValue({tag, " active"}, int'(active), mAct);
        checkValue({tag, " line"},   int'(line),   mN / T_LINE);
        checkValue({tag, " pixel"},  int'(pixel),  mN % T_LINE);
    endtask

    // Async reset pulse between clock edges; outputs must clear before any edge.
    task automatic resetPulse(input string tag);
        #2 reset_n = 1'b0;
        #1;
        checkValue({tag, " async cvbs"},   int'(cvbs),   12);
        checkValue({tag, " async hsync"},  int'(hsync),  0);
        checkValue({tag, " async vsync"},  int'(vsync),  0);
        checkValue({tag, " async active"}, int'(active), 0);
        checkValue({tag, " async line"},   int'(line),   0);
        checkValue({tag, " async pixel"},  int'(pixel),  0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        modelReset();
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset_n  = 1'b0;
        ce       = 1'b0;
        pixel_in = '0;

        vecs[0]  = '{0,    0,  0,  0, 1, 1, 0};
        vecs[1]  = '{0,  719,  0,  0, 1, 1, 0};
        vecs[2]  = '{0,  720,  0, 12, 0, 1, 0};
        vecs[3]  = '{0,  768,  0,  0, 1, 1, 0};
        vecs[4]  = '{1, 1487,  0,  0, 1, 1, 0};
        vecs[5]  = '{1, 1488,  0, 12, 0, 1, 0};
        vecs[6]  = '{2,  719,  0,  0, 1, 1, 0};
        vecs[7]  = '{2,  767,  0, 12, 0, 1, 0};
        vecs[8]  = '{2,  815,  0,  0, 1, 1, 0};
        vecs[9]  = '{2,  816,  0, 12, 0, 1, 0};
        vecs[10] = '{3,   47,  0,  0, 1, 1, 0};
        vecs[11] = '{3,   48,  0, 12, 0, 1, 0};
        vecs[12] = '{3,  768,  0,  0, 1, 1, 0};
        vecs[13] = '{5,  816,  0, 12, 0, 1, 0};
        vecs[14] = '{6,   40,  0,  0, 1, 0, 0};
        vecs[15] = '{10,  39,  0, 12, 0, 0, 0};
        vecs[16] = '{10,  40,  0,  0, 1, 0, 0};
        vecs[17] = '{10, 152,  0,  0, 1, 0, 0};
        vecs[18] = '{10, 153,  0, 12, 0, 0, 0};
        vecs[19] = '{23, 290,  5, 12, 0, 0, 0};
        vecs[20] = '{23,1535,  5, 12, 0, 0, 0};
        vecs[21] = '{24, 289,  5, 12, 0, 0, 0};
        vecs[22] = '{24, 290,  5, 17, 0, 0, 1};
        vecs[23] = '{24,1535, 60, 63, 0, 0, 1};
        vecs[24] = '{25, 700, 51, 63, 0, 0, 1};
        vecs[25] = '{25, 701, 50, 62, 0, 0, 1};
        vecs[26] = '{25, 702,  0, 12, 0, 0, 1};
        vecs[27] = '{26,   0,  0,  0, 1, 1, 0};

        @(posedge clk);
        #1;
        checkValue("reset cvbs",   int'(cvbs),   12);
        checkValue("reset hsync",  int'(hsync),  0);
        checkValue("reset vsync",  int'(vsync),  0);
        checkValue("reset active", int'(active), 0);
        checkValue("reset line",   int'(line),   0);
        checkValue("reset pixel",  int'(pixel),  0);
        reset_n = 1'b1;

        // Table phase: free run at ce=1, checking hand-computed samples.
        tabN = 0;
        for (int i = 0; i < 28; i++) begin
            int target;
            int nxt;
            string tag;
            target = vecs[i].l * T_LINE + vecs[i].p;
            while (tabN < target) begin
                clockOnce(1'b1, 6'd0);
                tabN++;
            end
            clockOnce(1'b1, 6'(vecs[i].pin));
            tabN++;
            nxt = (target + 1) % T_FRAME;
            tag = $sformatf("vec%0d L%0d P%0d", i, vecs[i].l, vecs[i].p);
            checkValue({tag, " cvbs"},   int'(cvbs),   vecs[i].cv);
            checkValue({tag, " hsync"},  int'(hsync),  vecs[i].hs);
            checkValue({tag, " vsync"},  int'(vsync),  vecs[i].vs);
            checkValue({tag, " active"}, int'(active), vecs[i].act);
            checkValue({tag, " line"},   int'(line),   nxt / T_LINE);
            checkValue({tag, " pixel"},  int'(pixel),  nxt % T_LINE);
        end

        // Model phase: cold restart, then alternating and random ce traffic.
        resetPulse("rst1");
        checkOutput("post rst1");
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(logic'(i % 2 == 0), 6'($urandom_range(0, 63)));
            checkOutput("alt ce");
        end
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(logic'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
            checkOutput("rand ce");
        end

        // Run to the middle of a blanking line, then reset asynchronously.
        while (mN != 10 * T_LINE + 700) begin
            applyStimulus(1'b1, 6'($urandom_range(0, 63)));
        end
        checkOutput("pre rst2");
        resetPulse("rst2");
        checkOutput("post rst2");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(logic'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)));
            checkOutput("after rst2");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
